fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RV32I core; owns the program counter and the IF/ID pipeline register.
- Drives the address input of the asynchronous instruction ROM and captures the 32-bit little-endian word it returns in the same cycle.
- Applies next-PC selection (sequential, branch, JALR), stall and flush control, and traps illegal fetch addresses.
- Feeds the decode stage.

---
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC select, fetch-address
// trap and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int unsigned                 ADDRESS_WIDTH     = 32,
  parameter int unsigned                 INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]    RESET_VECTOR      = 32'hBFC00000,
  parameter logic [ADDRESS_WIDTH-1:0]    ROM_BYTES         = 32'h1000,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR        = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [1:0]                   pc_src_i,
  input  logic [ADDRESS_WIDTH-1:0]     branch_target_i,
  input  logic [ADDRESS_WIDTH-1:0]     jalr_target_i,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr_o,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rd_i,
  output logic [INSTRUCTION_WIDTH-1:0] if_id_instr_o,
  output logic [ADDRESS_WIDTH-1:0]     if_id_pc_o,
  output logic [ADDRESS_WIDTH-1:0]     if_id_pc_plus4_o,
  output logic                         if_id_valid_o,
  output logic                         fault_o,
  output logic [ADDRESS_WIDTH-1:0]     fault_addr_o,
  output logic [31:0]                  fetch_count_o
);

  localparam logic [ADDRESS_WIDTH-1:0] FOUR      = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] JALR_MASK = ~ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ROM_LAST  = RESET_VECTOR + ROM_BYTES - FOUR;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc, pc_plus4, npc;
  logic                     redirect, pc_upd, npc_legal, run, take_fault;

  assign imem_addr_o = pc;
  assign pc_plus4    = pc + FOUR;
  assign redirect    = (pc_src_i == 2'b01) || (pc_src_i == 2'b10);
  // A redirect moves the PC even while decode is stalled.
  assign pc_upd      = redirect || !stall_i;

  // Next-PC select; reserved encoding falls back to sequential.
  always_comb begin
    npc = pc_plus4;
    case (pc_src_i)
      2'b01:   npc = branch_target_i;
      2'b10:   npc = jalr_target_i & JALR_MASK;
      default: npc = pc_plus4;
    endcase
  end

  assign npc_legal = (npc[1:0] == 2'b00) && (npc >= RESET_VECTOR) && (npc <= ROM_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state: only an illegal next-PC on an updating edge leaves RUN; FAULT is terminal.
  always_comb begin
    state_nxt = state;
    if (state == RUN && pc_upd && !npc_legal) state_nxt = FAULT;
  end

  // State decode used by the datapath.
  always_comb begin
    run        = (state == RUN);
    take_fault = run && pc_upd && !npc_legal;
  end

  // Program counter; frozen once faulted and on the faulting edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     pc <= RESET_VECTOR;
    else if (run && !take_fault && pc_upd) pc <= npc;
  end

  // IF/ID register. The word at the current PC is legal even when the next
  // PC is not, so the faulting edge still captures it normally; bubbles are
  // forced only from the following edge on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr_o    <= NOP_INSTR;
      if_id_pc_o       <= '0;
      if_id_pc_plus4_o <= '0;
      if_id_valid_o    <= 1'b0;
      fetch_count_o    <= '0;
    end else if (!run) begin
      if_id_instr_o    <= NOP_INSTR;
      if_id_valid_o    <= 1'b0;
    end else if (flush_i) begin
      if_id_instr_o    <= NOP_INSTR;
      if_id_pc_o       <= pc;
      if_id_pc_plus4_o <= pc_plus4;
      if_id_valid_o    <= 1'b0;
    end else if (!stall_i) begin
      if_id_instr_o    <= imem_rd_i;
      if_id_pc_o       <= pc;
      if_id_pc_plus4_o <= pc_plus4;
      if_id_valid_o    <= 1'b1;
      fetch_count_o    <= fetch_count_o + 32'd1;
    end
  end

  // Sticky fault flag and the offending next-PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_o      <= 1'b0;
      fault_addr_o <= '0;
    end else if (take_fault) begin
      fault_o      <= 1'b1;
      fault_addr_o <= npc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage with a reference model and an
// expected-result queue checked one edge after each drive.
module tb_fetch_stage;

  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam logic [31:0] LAST = 32'hBFC00FFC;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] bt, jt, imem_addr, imem_rd;
  logic [31:0] id_instr, id_pc, id_pc4, fault_addr, fcount;
  logic        id_valid, fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc, instr, idpc, idpc4, faddr, cnt;
    logic        valid, fault;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_faddr, m_cnt;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign imem_rd = rom(imem_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush), .pc_src_i(pc_src),
    .branch_target_i(bt), .jalr_target_i(jt), .imem_addr_o(imem_addr), .imem_rd_i(imem_rd),
    .if_id_instr_o(id_instr), .if_id_pc_o(id_pc), .if_id_pc_plus4_o(id_pc4),
    .if_id_valid_o(id_valid), .fault_o(fault), .fault_addr_o(fault_addr), .fetch_count_o(fcount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_instr = NOP; m_idpc = 0; m_idpc4 = 0; m_valid = 0;
    m_fault = 0; m_faddr = 0; m_cnt = 0;
    q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  imem_addr, RV);
    chk({tag, "_instr"}, id_instr,  NOP);
    chk({tag, "_pc"},    id_pc,     0);
    chk({tag, "_pc4"},   id_pc4,    0);
    chk({tag, "_valid"}, {31'd0, id_valid}, 0);
    chk({tag, "_fault"}, {31'd0, fault},    0);
    chk({tag, "_faddr"}, fault_addr, 0);
    chk({tag, "_cnt"},   fcount,     0);
  endtask

  // Drive one cycle, push the model's prediction, pop and compare after the edge.
  task automatic step(input logic s, input logic f, input logic [1:0] src,
                      input logic [31:0] b, input logic [31:0] j);
    logic [31:0] npc;
    logic        redir, upd, legal;
    exp_t        e, o;
    stall = s; flush = f; pc_src = src; bt = b; jt = j;
    redir = (src == 2'b01) || (src == 2'b10);
    npc   = (src == 2'b01) ? b : (src == 2'b10) ? {j[31:1], 1'b0} : m_pc + 32'd4;
    upd   = redir || !s;
    legal = (npc[1:0] == 0) && (npc >= RV) && (npc <= LAST);
    if (m_fault) begin
      m_instr = NOP; m_valid = 0;
    end else begin
      if (f) begin
        m_instr = NOP; m_valid = 0; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
      end else if (!s) begin
        m_instr = rom(m_pc); m_valid = 1; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
      if (upd && !legal) begin
        m_fault = 1; m_faddr = npc;
      end else if (upd) m_pc = npc;
    end
    e.pc = m_pc; e.instr = m_instr; e.idpc = m_idpc; e.idpc4 = m_idpc4;
    e.valid = m_valid; e.fault = m_fault; e.faddr = m_faddr; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk); #1;
    o = q.pop_front();
    chk("addr",  imem_addr, o.pc);
    chk("instr", id_instr,  o.instr);
    chk("idpc",  id_pc,     o.idpc);
    chk("idpc4", id_pc4,    o.idpc4);
    chk("valid", {31'd0, id_valid}, {31'd0, o.valid});
    chk("fault", {31'd0, fault},    {31'd0, o.fault});
    chk("faddr", fault_addr, o.faddr);
    chk("cnt",   fcount,     o.cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; pc_src = 0; bt = 0; jt = 0;
    model_reset();
    #12;
    chk_reset("por");
    @(negedge clk); rst_n = 1;

    // Free-running fetch of W0..W3
    run(4);
    chk("free_cnt", fcount, 32'd4);
    chk("free_pc",  id_pc,  RV + 32'hC);
    chk("free_w3",  id_instr, rom(RV + 32'hC));

    // Stall two cycles then resume
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 0);
    chk("stall_cnt", fcount, 32'd4);
    run(2);
    chk("resume_pc", id_pc, RV + 32'h14);

    // Branch with flush, then capture at target
    step(0, 1, 2'b01, RV + 32'h100, 0);
    chk("br_addr",  imem_addr, RV + 32'h100);
    chk("br_instr", id_instr,  NOP);
    run(1);
    chk("br_cap", id_instr, rom(RV + 32'h100));

    // Reserved pc_src behaves as sequential
    step(0, 0, 2'b11, 32'h0, 32'h0);

    // Stall + redirect: PC moves, IF/ID holds; then with flush
    step(1, 0, 2'b01, RV + 32'h200, 0);
    chk("stbr_addr", imem_addr, RV + 32'h200);
    step(1, 1, 2'b01, RV + 32'h300, 0);
    chk("stbr_flush_valid", {31'd0, id_valid}, 0);

    // JALR: odd target aligns, misaligned-by-2 faults
    step(0, 0, 2'b10, 0, RV + 32'h41);
    chk("jalr_addr", imem_addr, RV + 32'h40);
    chk("jalr_nf", {31'd0, fault}, 0);
    step(0, 0, 2'b10, 0, RV + 32'h42);
    chk("jf_fault", {31'd0, fault}, 1);
    chk("jf_faddr", fault_addr, RV + 32'h42);
    chk("jf_addr",  imem_addr, RV + 32'h40);
    step(0, 0, 2'b01, RV, 0);
    step(1, 1, 2'b00, 0, 0);
    chk("jf_valid", {31'd0, id_valid}, 0);
    do_reset();

    // Sequential overrun at the last ROM word
    step(0, 0, 2'b01, LAST - 32'hC, 0);
    run(3);
    chk("ovr_nf", {31'd0, fault}, 0);
    run(1);
    chk("ovr_fault", {31'd0, fault}, 1);
    chk("ovr_faddr", fault_addr, RV + 32'h1000);
    chk("ovr_idpc",  id_pc, LAST);
    chk("ovr_valid", {31'd0, id_valid}, 1);
    chk("ovr_instr", id_instr, rom(LAST));
    run(2);
    #2;
    do_reset();

    // Random mix of controls within and around the ROM window
    for (int i = 0; i < 60; i++) begin
      logic [31:0] tb_t, tj_t;
      tb_t = RV + ($urandom_range(0, 32'h1003) & 32'hFFFF_FFFC);
      tj_t = RV + $urandom_range(0, 32'hFFF);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, tb_t, tj_t);
      if (fault && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
